fetch: RTL and testbench

//  Instruction fetch stage, directly upstream of decode. Owns the 64-bit PC and issues

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_queue.sv | 64 ++++++
 rtl/fetch.sv | 169 ++++++++++++++++
 tb/tb_fetch.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_entry_t     {pc, instr, misalign} record handed to decode
//   RESET_PC_DEFAULT  default PC after reset
//   INSTR_NOP         canonical nop (addi x0,x0,0) used for trap entries
package fetch_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO with flush.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   push, din    write request / data (accepted when not full, or full with a pop)
//   pop          read request (ignored when empty)
//   flush        empties the FIFO, overrides push/pop
//   dout         head entry, stable until popped
//   full, empty, count  occupancy status
module fetch_queue #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-2 depths also work.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // Pop happens first, so a full queue may accept a push in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch.sv
// fetch: instruction fetch stage. Owns the PC, issues word requests to
// instruction memory, buffers {pc, instr} pairs and hands them to decode.
// Redirects flush the queue and drop responses still in flight.
// Build option: FETCH_MISALIGN_TRAP_EN -- a misaligned redirect target
// produces one misalign-flagged nop entry and stalls fetch until the next
// redirect. Without it the target's low two bits are cleared.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   imem_req_valid/ready/addr       request port to instruction memory
//   imem_rsp_valid/data             in-order responses, always accepted
//   redirect, redirect_pc           branch/jump redirect from execute
//   out_valid/out_ready/out_entry   fetch_entry_t handshake to decode
module fetch
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned MAX_OUTSTND = 2
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [63:0]  imem_req_addr,
  input  logic         imem_rsp_valid,
  input  logic [31:0]  imem_rsp_data,
  input  logic         redirect,
  input  logic [63:0]  redirect_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output fetch_entry_t out_entry
);

  localparam int unsigned QCW = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned SCW = $clog2(MAX_OUTSTND + 1);
  localparam int unsigned OW  = $clog2(MAX_OUTSTND + 1);

  logic [63:0]  pc_q;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] drop;
  logic [63:0]  redirect_tgt;
  logic         stall;
  logic         req_fire;
  logic         rsp_take;
  logic         credit_ok;

  logic         q_push;
  logic         q_pop;
  logic         q_full;
  logic         q_empty;
  logic [QCW-1:0] q_count;
  fetch_entry_t q_din;
  fetch_entry_t q_dout;

  logic [63:0]  sh_dout;
  logic         sh_full;
  logic         sh_empty;
  logic [SCW-1:0] sh_count;
  logic         unused_status;

  assign unused_status = ^{q_full, sh_count};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_pend;
  logic misaligned;

  assign misaligned   = |redirect_pc[1:0];
  assign redirect_tgt = redirect_pc;
`else
  assign redirect_tgt = {redirect_pc[63:2], 2'b00};
  assign stall        = 1'b0;
`endif

  // Credit rule: every in-flight request already owns a queue slot.
  assign credit_ok = (32'(outstanding) + 32'(q_count) < QUEUE_DEPTH) &&
                     (32'(outstanding) < MAX_OUTSTND) && !sh_full;

  assign imem_req_valid = !reset && !redirect && !stall && credit_ok;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses are taken only when not owed to a pre-redirect request.
  assign rsp_take = imem_rsp_valid && (drop == '0) && !redirect && !sh_empty;

  always_comb begin
    q_din          = '0;
    q_din.pc       = sh_dout;
    q_din.instr    = imem_rsp_data;
    q_din.misalign = 1'b0;
    q_push         = rsp_take;
`ifdef FETCH_MISALIGN_TRAP_EN
    // pc_q holds the misaligned target while the trap entry is pending.
    if (trap_pend) begin
      q_din.pc       = pc_q;
      q_din.instr    = INSTR_NOP;
      q_din.misalign = 1'b1;
      q_push         = 1'b1;
    end
`endif
  end

  assign q_pop     = out_ready && !redirect;
  assign out_valid = !q_empty;
  assign out_entry = q_dout;

  fetch_queue #(.WIDTH(ENTRY_W), .DEPTH(QUEUE_DEPTH)) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect),
    .din   (q_din),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // In-order PC of each in-flight request, matched to its response.
  fetch_queue #(.WIDTH(64), .DEPTH(MAX_OUTSTND)) u_pc_shadow (
    .clk   (clk),
    .reset (reset),
    .push  (req_fire),
    .pop   (rsp_take),
    .flush (redirect),
    .din   (pc_q),
    .dout  (sh_dout),
    .full  (sh_full),
    .empty (sh_empty),
    .count (sh_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      case ({req_fire, imem_rsp_valid})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (redirect) begin
        pc_q <= redirect_tgt;
        // Everything still in flight after this cycle belongs to the old path.
        drop <= outstanding - OW'(imem_rsp_valid);
      end else begin
        if (imem_rsp_valid && (drop != '0)) drop <= drop - 1'b1;
        if (req_fire) pc_q <= pc_q + 64'd4;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall     <= 1'b0;
      trap_pend <= 1'b0;
    end else if (redirect) begin
      stall     <= misaligned;
      trap_pend <= misaligned;
    end else begin
      trap_pend <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fetch.sv
module tb_fetch;
  import fetch_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [63:0]  imem_req_addr;
  logic         imem_rsp_valid;
  logic [31:0]  imem_rsp_data;
  logic         redirect;
  logic [63:0]  redirect_pc;
  logic         out_valid;
  logic         out_ready;
  fetch_entry_t out_entry;

  always #5 clk = ~clk;

  fetch dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_entry      (out_entry)
  );

  localparam bit TRAP =
`ifdef FETCH_MISALIGN_TRAP_EN
    1'b1;
`else
    1'b0;
`endif

  typedef struct {
    logic [63:0] addr;
    int          epoch;
  } req_t;

  typedef struct {
    logic [63:0] target;
    bit          exp_issue;
    logic [63:0] exp0;
    logic [63:0] exp1;
    logic [63:0] exp2;
    int          cycles;
  } vec_t;

  req_t         pend[$];
  logic [63:0]  iss[$];
  fetch_entry_t exp_q[$];
  fetch_entry_t popped[$];

  int          checks = 0;
  int          failures = 0;
  int          epoch = 0;
  int          rsp_epoch = -1;
  logic [63:0] rsp_addr;
  logic [63:0] exp_pc;
  logic [63:0] trap_pc;
  bit          stalled = 0;
  bit          trap_pend = 0;
  logic        mem_hold;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[33:2] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Memory: one-cycle latency, in order; mem_hold stalls responses.
  always @(posedge clk) begin
    req_t p;
    #1;
    if (!reset && !mem_hold && pend.size() > 0) begin
      p              = pend.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(p.addr);
      rsp_addr       = p.addr;
      rsp_epoch      = p.epoch;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  // Monitor + scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    fetch_entry_t e;
    if (reset) begin
      exp_q.delete();
      pend.delete();
      epoch++;
      stalled   = 0;
      trap_pend = 0;
      exp_pc    = RESET_PC_DEFAULT;
    end else begin
      chk("out_valid_vs_model", out_valid, exp_q.size() != 0);
      if (out_valid && out_ready && !redirect) begin
        if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_entry", out_entry, e);
          popped.push_back(out_entry);
        end
      end
      if (redirect) begin
        chk("no_req_on_redirect", imem_req_valid, 0);
        exp_q.delete();
        epoch++;
        if (TRAP && redirect_pc[1:0] != 2'b00) begin
          stalled   = 1;
          trap_pend = 1;
          trap_pc   = redirect_pc;
        end else begin
          stalled = 0;
          exp_pc  = {redirect_pc[63:2], 2'b00};
        end
      end else if (trap_pend) begin
        e.pc = trap_pc; e.instr = INSTR_NOP; e.misalign = 1'b1;
        exp_q.push_back(e);
        trap_pend = 0;
      end else if (imem_rsp_valid && rsp_epoch == epoch) begin
        e.pc = rsp_addr; e.instr = instr_of(rsp_addr); e.misalign = 1'b0;
        exp_q.push_back(e);
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, exp_pc);
        if (stalled) chk("req_while_stalled", 1, 0);
        pend.push_back('{addr: imem_req_addr, epoch: epoch});
        iss.push_back(imem_req_addr);
        exp_pc = exp_pc + 64'd4;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic hold);
    reset    = 1'b1;
    redirect = 1'b0;
    mem_hold = hold;
    cyc(3);
    iss.delete();
    popped.delete();
    reset = 1'b0;
  endtask

  task automatic pulse_redirect(input logic [63:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    iss.delete();
    popped.delete();
    cyc(1);
    redirect = 1'b0;
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{64'h1000, 1'b1, 64'h1000, 64'h1004, 64'h1008, 12};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8,
                64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 12};
    vecs[2] = '{64'h1002, !TRAP, 64'h1000, 64'h1004, 64'h1008, 12};
    vecs[3] = '{64'h2004, 1'b1, 64'h2004, 64'h2008, 64'h200C, 12};

    reset          = 1'b1;
    redirect       = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    imem_req_ready = 1'b1;
    mem_hold       = 1'b0;

    // Reset state and first-transaction latency.
    cyc(3);
    @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    cyc(1);
    reset = 1'b0;
    iss.delete();
    popped.delete();
    @(negedge clk);
    chk("c0_req_valid", imem_req_valid, 1);
    chk("c0_req_addr", imem_req_addr, 64'h8000_0000);
    chk("c0_out_valid", out_valid, 0);
    @(negedge clk);
    chk("c1_rsp_valid", imem_rsp_valid, 1);
    chk("c1_out_valid", out_valid, 0);
    @(negedge clk);
    chk("c2_out_valid", out_valid, 1);
    chk("c2_out_pc", out_entry.pc, 64'h8000_0000);
    cyc(6);
    chk("t1_iss_n", iss.size() >= 3, 1);
    chk("t1_pop_n", popped.size() >= 3, 1);
    if (iss.size() >= 3 && popped.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("t1_iss_addr", iss[i], 64'h8000_0000 + 64'(4 * i));
        chk("t1_pop_pc", popped[i].pc, 64'h8000_0000 + 64'(4 * i));
        chk("t1_pop_instr", popped[i].instr, instr_of(64'h8000_0000 + 64'(4 * i)));
      end
    end

    // Backpressure: queue fills to depth, then drains in order.
    out_ready = 1'b0;
    do_reset(1'b0);
    cyc(20);
    chk("t2_iss_n", iss.size(), 4);
    chk("t2_req_valid", imem_req_valid, 0);
    chk("t2_out_valid", out_valid, 1);
    out_ready = 1'b1;
    cyc(20);
    chk("t2_pop_n", popped.size() >= 4, 1);
    if (popped.size() >= 4)
      for (int i = 0; i < 4; i++)
        chk("t2_pop_pc", popped[i].pc, 64'h8000_0000 + 64'(4 * i));

    // Redirect with two requests in flight.
    do_reset(1'b1);
    cyc(4);
    chk("t3_inflight", pend.size(), 2);
    chk("t3_req_blocked", imem_req_valid, 0);
    pulse_redirect(64'h1000);
    mem_hold = 1'b0;
    @(negedge clk);
    chk("t3_q_empty", out_valid, 0);
    cyc(10);
    chk("t3_iss_n", iss.size() > 0, 1);
    if (iss.size() > 0) chk("t3_first_addr", iss[0], 64'h1000);
    chk("t3_pop_n", popped.size() > 0, 1);
    if (popped.size() > 0) chk("t3_first_pc", popped[0].pc, 64'h1000);

    // Redirect coincident with a response and a ready decode.
    do_reset(1'b0);
    cyc(6);
    chk("t4_pre_rsp", imem_rsp_valid, 1);
    chk("t4_pre_out", out_valid, 1);
    pulse_redirect(64'h3000);
    @(negedge clk);
    chk("t4_flushed", out_valid, 0);
    cyc(8);
    chk("t4_pop_n", popped.size() > 0, 1);
    if (popped.size() > 0) chk("t4_first_pc", popped[0].pc, 64'h3000);

    // Redirect table: aligned, wrap, misaligned, aligned recovery.
    foreach (vecs[k]) begin
      pulse_redirect(vecs[k].target);
      cyc(vecs[k].cycles);
      if (vecs[k].exp_issue) begin
        chk("tv_iss_n", iss.size() >= 3, 1);
        if (iss.size() >= 3) begin
          chk("tv_addr0", iss[0], vecs[k].exp0);
          chk("tv_addr1", iss[1], vecs[k].exp1);
          chk("tv_addr2", iss[2], vecs[k].exp2);
        end
      end else begin
        chk("tv_no_req", iss.size(), 0);
        chk("tv_trap_n", popped.size(), 1);
        if (popped.size() == 1) begin
          chk("tv_trap_misalign", popped[0].misalign, 1);
          chk("tv_trap_pc", popped[0].pc, vecs[k].target);
          chk("tv_trap_instr", popped[0].instr, INSTR_NOP);
        end
      end
    end

    // Mid-stream reset discards everything.
    do_reset(1'b0);
    @(negedge clk);
    chk("rst2_req_addr", imem_req_addr, 64'h8000_0000);
    cyc(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
